// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter:
// FSM states, requester IDs and counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_INSTR,
    REQ_DATA
  } req_id_e;

endpackage

// File: rtl/arb_latency_timer.sv
// Loadable down-counter; done when count hits DONE_AT.
// Ports: clk, rst (async low), load, load_val, dec, done.
module arb_latency_timer
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] DONE_AT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == DONE_AT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and load/store onto one fixed-latency memory port.
// Ports: clk, rst (async low), instr_*, data_*, mem_*. Macro: ARB_STARVE_GUARD_EN.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  output logic        instr_stall,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        mem_read,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e state, state_nxt;
  req_id_e    owner;
  logic [3:0] be_q;

  logic data_req;
  logic idle;
  logic grant_i;
  logic grant_d;
  logic starve_hit;
  logic lat_done;
  logic capture;

  assign data_req = data_read | (|data_write);
  assign idle     = (state == IDLE);
  assign grant_i  = idle & instr_read & (~data_req | starve_hit);
  assign grant_d  = idle & data_req & ~grant_i;
  assign capture  = (state == WAIT) & lat_done;

  arb_latency_timer u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (state == CMD),
    .load_val (CNT_W'(MEM_LATENCY - 1)),
    .dec      ((state == WAIT) & ~lat_done),
    .done     (lat_done)
  );

`ifdef ARB_STARVE_GUARD_EN
  // Holds minus the run of starving data grants, so reset/clear (0)
  // means "no run" and each starving grant is a decrement.
  localparam logic [CNT_W-1:0] STARVE_AT =
    CNT_W'((1 << CNT_W) - STARVE_LIMIT);

  arb_latency_timer #(
    .DONE_AT (STARVE_AT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_i | (grant_d & ~instr_read)),
    .load_val ('0),
    .dec      (grant_d & instr_read),
    .done     (starve_hit)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (grant_i | grant_d) state_nxt = CMD;
      CMD:  state_nxt = (|be_q) ? RESP : WAIT;
      WAIT: if (lat_done) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= REQ_INSTR;
      be_q        <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instr_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      if (grant_i) begin
        owner    <= REQ_INSTR;
        be_q     <= '0;
        mem_addr <= instr_addr;
      end else if (grant_d) begin
        owner     <= REQ_DATA;
        be_q      <= data_write;
        mem_addr  <= data_addr;
        mem_wdata <= data_in;
      end
      if (capture) begin
        if (owner == REQ_INSTR) begin
          instr_rdata <= mem_rdata;
        end else begin
          data_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_read  = (state == CMD) & ~(|be_q);
  assign mem_write = (state == CMD) ? be_q : 4'b0000;

  assign instr_ack   = (state == RESP) & (owner == REQ_INSTR);
  assign data_ack    = (state == RESP) & (owner == REQ_DATA);
  assign instr_stall = instr_read & ~instr_ack;
  assign data_stall  = data_req & ~data_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: default latency
// instance plus a MEM_LATENCY=4 instance.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic        ir, iack, istall, dr, dack, dstall, mr;
  logic [31:0] ia, ird, da, din, drd, ma, mwd, md;
  logic [3:0]  dw, mw;

  logic        ir4, iack4, istall4, dack4, dstall4, mr4;
  logic [31:0] ia4, ird4, drd4, ma4, mwd4, md4;
  logic [3:0]  mw4;

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .instr_read(ir), .instr_addr(ia), .instr_ack(iack),
    .instr_rdata(ird), .instr_stall(istall),
    .data_read(dr), .data_write(dw), .data_addr(da),
    .data_in(din), .data_ack(dack), .data_rdata(drd),
    .data_stall(dstall), .mem_read(mr), .mem_write(mw),
    .mem_addr(ma), .mem_wdata(mwd), .mem_rdata(md)
  );

  unified_mem_arbiter #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .instr_read(ir4), .instr_addr(ia4), .instr_ack(iack4),
    .instr_rdata(ird4), .instr_stall(istall4),
    .data_read(1'b0), .data_write(4'b0000), .data_addr(32'h0),
    .data_in(32'h0), .data_ack(dack4), .data_rdata(drd4),
    .data_stall(dstall4), .mem_read(mr4), .mem_write(mw4),
    .mem_addr(ma4), .mem_wdata(mwd4), .mem_rdata(md4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch4(input logic [31:0] a, input logic [31:0] w);
    ir4 = 1'b1; ia4 = a; #1;
    check("f4_stall", {31'b0, istall4}, 1);
    nxt();
    check("f4_mrd", {31'b0, mr4}, 1);
    check("f4_addr", ma4, a);
    nxt(); nxt(); nxt();
    md4 = ~w;
    nxt();
    md4 = w; #1;
    check("f4_early_ack", {31'b0, iack4}, 0);
    nxt();
    check("f4_ack", {31'b0, iack4}, 1);
    check("f4_data", ird4, w);
    ir4 = 1'b0; md4 = '0;
    nxt();
    check("f4_ack_off", {31'b0, iack4}, 0);
  endtask

  int ni, nd, n;

  initial begin
    ir = 0; ia = 0; dr = 0; dw = 0; da = 0; din = 0; md = 0;
    ir4 = 0; ia4 = 0; md4 = 0;
    #1;
    check("rst_ack", {30'b0, iack, dack}, 0);
    check("rst_mem", {27'b0, mr, mw}, 0);
    check("rst_addr", ma, 0);
    check("rst_rd", ird | drd, 0);
    nxt();
    rst = 1'b1;
    nxt();

    // single fetch
    ir = 1; ia = 32'h100; #1;
    check("f_stall0", {31'b0, istall}, 1);
    check("f_mrd0", {31'b0, mr}, 0);
    nxt();
    check("f_mrd1", {31'b0, mr}, 1);
    check("f_addr1", ma, 32'h100);
    check("f_stall1", {31'b0, istall}, 1);
    nxt();
    md = 32'h00500093; #1;
    check("f_ack2", {31'b0, iack}, 0);
    check("f_stall2", {31'b0, istall}, 1);
    check("f_mrd2", {31'b0, mr}, 0);
    nxt();
    check("f_ack3", {31'b0, iack}, 1);
    check("f_data3", ird, 32'h00500093);
    check("f_stall3", {31'b0, istall}, 0);
    ir = 0; md = 0;
    nxt();
    check("f_ack4", {31'b0, iack}, 0);

    // simultaneous requests, data first
    ir = 1; ia = 32'h104; dr = 1; da = 32'h2000;
    nxt();
    check("s_addr1", ma, 32'h2000);
    nxt();
    md = 32'hAAAA5555;
    nxt();
    check("s_dack3", {31'b0, dack}, 1);
    check("s_iack3", {31'b0, iack}, 0);
    check("s_drd3", drd, 32'hAAAA5555);
    dr = 0;
    nxt();
    nxt();
    check("s_mrd5", {31'b0, mr}, 1);
    check("s_addr5", ma, 32'h104);
    nxt();
    md = 32'h12345678;
    nxt();
    check("s_iack7", {31'b0, iack}, 1);
    check("s_ird7", ird, 32'h12345678);
    check("s_drd7", drd, 32'hAAAA5555);
    ir = 0; md = 0;
    nxt();

    // store
    dw = 4'b0011; da = 32'h2004; din = 32'hDEADBEEF; #1;
    check("w_stall0", {31'b0, dstall}, 1);
    nxt();
    check("w_mw1", {28'b0, mw}, 32'h3);
    check("w_wd1", mwd, 32'hDEADBEEF);
    check("w_addr1", ma, 32'h2004);
    check("w_mrd1", {31'b0, mr}, 0);
    nxt();
    check("w_ack2", {31'b0, dack}, 1);
    check("w_mw2", {28'b0, mw}, 0);
    check("w_stall2", {31'b0, dstall}, 0);
    check("w_drd2", drd, 32'hAAAA5555);
    dw = 0;
    nxt();

    // read+write together is a store
    dr = 1; dw = 4'hF; da = 32'h2008; din = 32'h0F0F0F0F;
    nxt();
    check("rw_mw", {28'b0, mw}, 32'hF);
    check("rw_mrd", {31'b0, mr}, 0);
    nxt();
    check("rw_ack", {31'b0, dack}, 1);
    dr = 0; dw = 0;
    nxt();

    // latency 4 with an early decoy value
    fetch4(32'h300, 32'hC0FFEE01);

    // reset during WAIT
    ir4 = 1; ia4 = 32'h400;
    nxt(); nxt(); nxt();
    md4 = 32'h55555555; rst = 0; ir4 = 0; #1;
    check("r_addr", ma4, 0);
    check("r_ird", ird4, 0);
    check("r_mrd", {31'b0, mr4}, 0);
    check("r_out", {29'b0, iack4, istall4, dack4}, 0);
    nxt();
    rst = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (iack4) n++;
    end
    check("r_noack", n, 0);
    check("r_ird_hold", ird4, 0);
    md4 = 0;
    fetch4(32'h404, 32'h0BADF00D);

    // starvation
    ir = 1; ia = 32'h500; dr = 1; da = 32'h3000; md = 32'h77;
    ni = 0; nd = 0;
    n = -1;
    for (int i = 0; i < 21; i++) begin
      #1;
      if (iack && n < 0) n = nd;
      if (iack) ni++;
      if (dack) nd++;
      nxt();
    end
`ifdef ARB_STARVE_GUARD_EN
    check("sv_dacks", nd, 4);
    check("sv_iacks", ni, 1);
    check("sv_order", n, 4);
`else
    check("sv_dacks", nd, 5);
    check("sv_iacks", ni, 0);
`endif
    ir = 0; dr = 0;
    for (int i = 0; i < 6; i++) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares a single unified instruction/data memory port between the fetch requester (PC side) and the data requester (load/store side) of the CPU. Sits between the core's `instr_*`/`data_*` request signals and one memory macro. It arbitrates requests, sequences each access through a fixed-latency memory, and returns read data with a one-cycle acknowledge. The core stalls on the requester's `*_stall` until that acknowledge.

## Interface
- `MEM_LATENCY`, default 1: cycles from memory command to valid `mem_rdata`; legal range 1..15.
- `STARVE_LIMIT`, default 4: consecutive data grants tolerated while fetch is pending; legal range 1..15. Used only with `ARB_STARVE_GUARD_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr_read`  in  1  fetch request; held until `instr_ack`.
- `instr_addr`  in  32  fetch byte address.
- `instr_ack`  out  1  one-cycle pulse; `instr_rdata` valid.
- `instr_rdata`  out  32  fetched word, registered.
- `instr_stall`  out  1  `instr_read & ~instr_ack`, combinational.
- `data_read`  in  1  load request; held until `data_ack`.
- `data_write`  in  4  byte-enable store request; nonzero means store; held until `data_ack`.
- `data_addr`  in  32  load/store byte address.
- `data_in`  in  32  store data.
- `data_ack`  out  1  one-cycle pulse.
- `data_rdata`  out  32  load word, registered.
- `data_stall`  out  1  `(data_read | (|data_write)) & ~data_ack`.
- `mem_read`  out  1  memory read command, one-cycle pulse.
- `mem_write`  out  4  memory byte write enables, one-cycle pulse.
- `mem_addr`  out  32  memory address, registered.
- `mem_wdata`  out  32  memory write data, registered.
- `mem_rdata`  in  32  memory read data.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP.
- **IDLE**
  - The data request is `data_read | (|data_write)`.
  - If both requesters are active, data wins. The older instruction must finish, so there is no pipeline deadlock.
  - On a grant: latch requester ID, address, write data and byte enables, then go to CMD.
  - If `data_read` and `data_write` are both set, treat the access as a store.
- **CMD**: drive `mem_read` or `mem_write` for exactly one cycle from registers.
  - Read: load the latency counter with `MEM_LATENCY-1` and go to WAIT. If `MEM_LATENCY`=1, go straight to the capture step described under WAIT.
  - Store: go to RESP.
- **WAIT**: count down to zero. In the cycle where the counter is 0, capture `mem_rdata` into the granted requester's `*_rdata`, then go to RESP.
- **RESP**: pulse the granted requester's `*_ack`, then return to IDLE.
  - Requests are not sampled in RESP, so a still-high `*_read` is not granted twice.
  - The requester must deassert or present its next request by the following cycle.
- `*_rdata` holds its value until the next read to the same requester completes.
- `mem_addr` and `mem_wdata` hold their values outside CMD. `mem_read` and `mem_write` are 0 outside CMD.
- Request signals changing while the arbiter is not in IDLE are ignored; the latched values are used.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs are 0; all registers, including the starve counter, are cleared.
  - An in-flight access is dropped; any later `mem_rdata` is ignored.

## Timing
- A request first seen in IDLE at cycle t gives the memory command at t+1.
- Read ack at t+2+`MEM_LATENCY`: default 3 cycles from request to ack, with ack in the 4th cycle.
- Store ack at t+2.
- Back-to-back accesses: the next grant happens in the cycle after RESP. Read throughput is one access per `MEM_LATENCY`+3 cycles.
- `*_stall` is combinational from request and ack, so it falls in the ack cycle.

## Configuration
- **`ARB_STARVE_GUARD_EN` defined**
  - A 4-bit counter increments on each data grant made while `instr_read` is high.
  - It clears on any fetch grant, and also clears on a data grant made while `instr_read` is low.
  - When the counter equals `STARVE_LIMIT` and both requesters are active in IDLE, fetch is granted.
- **Undefined**: strict data priority; the counter logic is absent.

## Structure
- Package `mem_arb_pkg` holds:
  - the FSM state enum typedef;
  - the requester-ID typedef (`REQ_INSTR`, `REQ_DATA`);
  - the latency counter width constant (4).
- Sub-module `arb_latency_timer`: a loadable down-counter with a `done` output. It is also reused for the starve counter.

## Test plan
- **Single fetch, default latency**: `instr_read`=1 with `instr_addr`=0x100 and memory returning 0x00500093.
  - `mem_read` pulses in cycle 1 with `mem_addr`=0x100.
  - `instr_ack`=1 with `instr_rdata`=0x00500093 in cycle 3.
  - `instr_stall` is 1 in cycles 0–2.
- **Simultaneous requests**: `instr_read`=1 and `data_read`=1 at `data_addr`=0x2000 in the same cycle.
  - `data_ack` comes first, in cycle 3.
  - `instr_ack` follows in cycle 7.
- **Store**: `data_write`=4'b0011, `data_addr`=0x2004, `data_in`=0xDEADBEEF.
  - `mem_write`=4'b0011 and `mem_wdata`=0xDEADBEEF in cycle 1.
  - `data_ack` in cycle 2; `mem_read` stays 0.
- **Latency sweep**: with `MEM_LATENCY`=4, a fetch's ack comes 6 cycles after the request. A `mem_rdata` value driven one cycle early is not captured.
- **Reset mid-WAIT**: assert `rst` low during WAIT.
  - All outputs go to 0 immediately.
  - After release, no ack appears.
  - A fresh request completes normally.
- **Starvation (`ARB_STARVE_GUARD_EN`, `STARVE_LIMIT`=4)**: `data_read` held continuously with `instr_read` high.
  - Exactly 4 data acks, then 1 instruction ack.
  - Without the macro, no instruction ack occurs.
